fifo_repl_ctrl: RTL and testbench
=================================

Name: fifo_repl_ctrl

Overview:
Parametrised FIFO replacement controller for an N-way set-associative cache with S sets. It generalises the fixed 2-way/8-line victim selector. New behaviour over that selector: per-set valid tracking, an invalid-first victim choice, a per-set FIFO pointer, explicit invalidation, and a request/allocate handshake with the cache controller. It sits beside the tag array: the controller presents each lookup, the block returns the victim way on a miss, and the controller confirms the refill.

Parameters:
WAYS, 4, associativity; power of 2, ≥2
SETS, 8, number of sets; power of 2, ≥2
WAY_W, log2(WAYS), way index width (derived)
IDX_W, log2(SETS), set index width (derived)

Ports:
clk  in  1  clock; all state updates on falling edge of clk
reset  in  1  synchronous, active-high reset
req_valid  in  1  lookup result presented
req_index  in  IDX_W  set of the lookup
req_hit  in  1  1 = lookup hit, 0 = miss
req_ready  out  1  block can accept a request
victim_valid  out  1  victim_way/victim_evict are valid; held until fill_done
victim_way  out  WAY_W  way to refill
victim_evict  out  1  1 = the chosen way holds a valid line (eviction needed)
fill_done  in  1  controller finished refilling victim_way
inv_valid  in  1  invalidate request
inv_index  in  IDX_W  set to invalidate
inv_way  in  WAY_W  way to invalidate

Behaviour:
- State per set: valid[WAYS] and ptr[WAY_W] (oldest way). Controller FSM has two states: IDLE and ALLOC.
- Reset (sampled on falling edge) sets all valid=0, all ptr=0, and FSM=IDLE. Reset values: req_ready=1, victim_valid=0, victim_way=0, victim_evict=0. Reset during ALLOC abandons the allocation with no valid/ptr update.
- IDLE: req_ready=1. A request is accepted on an edge with req_valid=1.
  - Hit accepted: no state change, no response; FSM stays IDLE.
  - Miss accepted: victim is computed from that set's state at that edge, then registered, and FSM→ALLOC.
    - If any valid bit is 0, victim = lowest-numbered invalid way, victim_evict=0.
    - Otherwise victim = ptr, victim_evict=1.
  - Latency: victim_valid goes high immediately after the accepting edge (1 edge).
- ALLOC: req_ready=0, and req_valid is ignored. victim_valid=1, with victim_way, victim_evict and the pending index stable.
  - fill_done=1 at an edge sets valid[pending_index][victim_way]=1.
  - On that same edge, if victim_evict=1, ptr[pending_index] ← ptr+1 mod WAYS (natural WAY_W wrap from WAYS-1 to 0).
  - On that same edge, FSM→IDLE; victim_valid=0 and req_ready=1 after that edge.
  - fill_done in IDLE is ignored.
- Pointer advances only on an evicting fill. Fills into invalid ways never move ptr. Hits never touch state (pure FIFO, not LRU).
- Invalidate is accepted in any state, at an edge with inv_valid=1: valid[inv_index][inv_way] ← 0. ptr is unchanged.
  - Same edge as fill_done, same set and way: the fill wins and the line ends valid.
  - Invalidate to another way of the pending set during ALLOC: applied. The already-registered victim is not recomputed.
  - Invalidate in the same edge as a miss acceptance, same set: victim selection uses pre-edge state.
- Victim logic is combinational over WAYS bits via a priority encoder; registered outputs only. No combinational path from inputs to outputs except req_ready, which is a function of FSM state.

Test Plan:
1. Reset → req_ready=1, victim_valid=0. Miss on set 3 → victim_way=0, victim_evict=0. fill_done → req_ready=1 on the next edge.
2. WAYS=4, four misses and fills on set 5 → victims 0,1,2,3 in order, all victim_evict=0, ptr[5]=0. Fifth miss → way 0, victim_evict=1. After fill, sixth miss → way 1, evict=1.
3. Ptr wrap: fill set 2 fully, then 4 evicting misses and fills → victims 0,1,2,3. Next evicting miss → way 0.
4. Set 1 full, ptr=2. Invalidate way 3, then miss on set 1 → victim_way=3, evict=0, and ptr stays 2. Next miss → way 2, evict=1.
5. Miss accepted on set 4 (victim 1). While ALLOC, pulse req_valid/miss on set 6 → ignored, req_ready=0. Hit on set 4 before the miss → no victim_valid.
6. In ALLOC for set 7 way 2, drive fill_done with inv_valid on (7,2) at the same edge → valid[7][2]=1. Repeat with reset asserted mid-ALLOC → victim_valid=0, and the next miss on set 7 returns way 0 with evict=0.

Source files
------------

// File: rtl/fifo_repl_ctrl.sv
// FIFO victim selector for an N-way, S-set cache. It tracks per-set valid bits and a FIFO pointer,
// and runs a request/allocate handshake with the cache controller. State updates on the falling clock edge.
module fifo_repl_ctrl #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int WAY_W = $clog2(WAYS),
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_index,
    input  logic             req_hit,
    output logic             req_ready,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_evict,
    input  logic             fill_done,
    input  logic             inv_valid,
    input  logic [IDX_W-1:0] inv_index,
    input  logic [WAY_W-1:0] inv_way,
    output logic             dbg_state
);

    // Handshake: a request transfers on an edge where req_valid && req_ready.
    // A miss raises victim_valid, which holds until the edge where fill_done is high.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ALLOC = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]             pend_idx_q, pend_idx_d;
    logic [WAY_W-1:0]             victim_way_q, victim_way_d;
    logic                         victim_evict_q, victim_evict_d;
    logic                         victim_valid_q, victim_valid_d;

    logic [WAYS-1:0]              set_valid;
    logic [WAY_W-1:0]             free_way;
    logic                         has_free;

    // The descending scan leaves the lowest-numbered invalid way in free_way.
    always_comb begin
        set_valid = valid_q[req_index];
        free_way  = '0;
        has_free  = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                free_way = WAY_W'(w);
                has_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        ptr_d          = ptr_q;
        pend_idx_d     = pend_idx_q;
        victim_way_d   = victim_way_q;
        victim_evict_d = victim_evict_q;
        victim_valid_d = victim_valid_q;

        // The invalidate is applied first, so a fill to the same line on this edge overrides it.
        if (inv_valid) begin
            valid_d[inv_index][inv_way] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && !req_hit) begin
                    state_d        = S_ALLOC;
                    pend_idx_d     = req_index;
                    victim_way_d   = has_free ? free_way : ptr_q[req_index];
                    victim_evict_d = !has_free;
                    victim_valid_d = 1'b1;
                end
            end
            S_ALLOC: begin
                if (fill_done) begin
                    valid_d[pend_idx_q][victim_way_q] = 1'b1;
                    if (victim_evict_q) begin
                        ptr_d[pend_idx_q] = ptr_q[pend_idx_q] + WAY_W'(1);
                    end
                    state_d        = S_IDLE;
                    victim_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = S_IDLE;
                victim_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            valid_q        <= '0;
            ptr_q          <= '0;
            pend_idx_q     <= '0;
            victim_way_q   <= '0;
            victim_evict_q <= 1'b0;
            victim_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            ptr_q          <= ptr_d;
            pend_idx_q     <= pend_idx_d;
            victim_way_q   <= victim_way_d;
            victim_evict_q <= victim_evict_d;
            victim_valid_q <= victim_valid_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign victim_evict = victim_evict_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fifo_repl_ctrl.sv
// Bench for fifo_repl_ctrl: directed scenarios followed by random traffic.
// A per-set reference model supplies the expected victims, and a posedge monitor checks the DUT against them.
module tb_fifo_repl_ctrl;

    localparam int WAYS  = 4;
    localparam int SETS  = 8;
    localparam int WAY_W = 2;
    localparam int IDX_W = 3;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic [IDX_W-1:0] req_index;
    logic             req_hit;
    logic             req_ready;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
    logic             victim_evict;
    logic             fill_done;
    logic             inv_valid;
    logic [IDX_W-1:0] inv_index;
    logic [WAY_W-1:0] inv_way;
    logic             dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_valid[SETS][WAYS];
    int m_ptr[SETS];
    bit m_alloc;
    int m_pidx;
    int m_way;
    bit m_evict;
    logic [WAY_W:0] exp_q[$];
    bit mon_en;
    bit vv_prev;

    fifo_repl_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_index(req_index), .req_hit(req_hit),
        .req_ready(req_ready),
        .victim_valid(victim_valid), .victim_way(victim_way), .victim_evict(victim_evict),
        .fill_done(fill_done),
        .inv_valid(inv_valid), .inv_index(inv_index), .inv_way(inv_way),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, advanced on the same falling edge at which the DUT samples its inputs.
    task automatic model_edge();
        int  v;
        int  idx;
        bit  acc;
        logic [WAY_W:0] e;
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                m_ptr[s] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            end
            m_alloc = 1'b0;
            return;
        end
        acc = !m_alloc && req_valid && !req_hit;
        idx = int'(req_index);
        v = -1;
        if (acc) begin
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[idx][w] && v < 0) v = w;
        end
        if (inv_valid) m_valid[inv_index][inv_way] = 1'b0;
        if (m_alloc && fill_done) begin
            m_valid[m_pidx][m_way] = 1'b1;
            if (m_evict) m_ptr[m_pidx] = (m_ptr[m_pidx] + 1) % WAYS;
            m_alloc = 1'b0;
        end else if (acc) begin
            m_alloc = 1'b1;
            m_pidx  = idx;
            if (v >= 0) begin
                m_way = v;
                m_evict = 1'b0;
            end else begin
                m_way = m_ptr[idx];
                m_evict = 1'b1;
            end
            e = {m_evict, m_way[WAY_W-1:0]};
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_edge();
        @(posedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic miss(input int idx);
        req_valid = 1'b1;
        req_index = IDX_W'(idx);
        req_hit = 1'b0;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic hit(input int idx);
        req_valid = 1'b1;
        req_index = IDX_W'(idx);
        req_hit = 1'b1;
        cyc();
        req_valid = 1'b0;
        req_hit = 1'b0;
    endtask

    task automatic fill();
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
    endtask

    task automatic inv(input int idx, input int way);
        inv_valid = 1'b1;
        inv_index = IDX_W'(idx);
        inv_way = WAY_W'(way);
        cyc();
        inv_valid = 1'b0;
    endtask

    task automatic chk_victim(input string name, input int way, input int evict);
        chk({name, "_valid"}, int'(victim_valid), 1);
        chk({name, "_way"}, int'(victim_way), way);
        chk({name, "_evict"}, int'(victim_evict), evict);
    endtask

    // Monitor: handshake outputs and the debug state follow the model every cycle; each new victim is checked against the scoreboard.
    always @(posedge clk) begin
        logic [WAY_W:0] e;
        if (mon_en) begin
            n_tests++;
            if (req_ready !== !m_alloc) begin
                n_fail++;
                $display("FAIL req_ready: got %b, expected %b", req_ready, !m_alloc);
            end
            n_tests++;
            if (victim_valid !== m_alloc) begin
                n_fail++;
                $display("FAIL victim_valid: got %b, expected %b", victim_valid, m_alloc);
            end
            n_tests++;
            if (dbg_state !== m_alloc) begin
                n_fail++;
                $display("FAIL dbg_state: got %b, expected %b", dbg_state, m_alloc);
            end
            if (victim_valid === 1'b1 && !vv_prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL victim_unexpected: got way %0d evict %b, expected none", victim_way, victim_evict);
                end else begin
                    e = exp_q.pop_front();
                    if ({victim_evict, victim_way} !== e) begin
                        n_fail++;
                        $display("FAIL victim: got evict %b way %0d, expected evict %b way %0d",
                                 victim_evict, victim_way, e[WAY_W], e[WAY_W-1:0]);
                    end
                end
            end
        end
        vv_prev = (victim_valid === 1'b1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        req_hit = 1'b0;
        fill_done = 1'b0;
        inv_valid = 1'b0;
        inv_index = '0;
        inv_way = '0;
        mon_en = 1'b0;
        vv_prev = 1'b0;
        m_alloc = 1'b0;
        @(posedge clk);
        cyc();
        cyc();
        chk("reset_victim_way", int'(victim_way), 0);
        chk("reset_victim_evict", int'(victim_evict), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        cyc();
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_victim_valid", int'(victim_valid), 0);

        // Scenario 1: the first miss takes invalid way 0.
        miss(3);
        chk_victim("t1_miss", 0, 0);
        chk("t1_busy", int'(req_ready), 0);
        fill();
        chk("t1_ready_after_fill", int'(req_ready), 1);

        // Scenario 2: the set fills in way order, then eviction follows the pointer.
        for (int i = 0; i < 4; i++) begin
            miss(5);
            chk_victim("t2_fill", i, 0);
            fill();
        end
        miss(5);
        chk_victim("t2_evict0", 0, 1);
        fill();
        miss(5);
        chk_victim("t2_evict1", 1, 1);
        fill();

        // Scenario 3: the pointer wraps from the last way back to 0.
        for (int i = 0; i < 4; i++) begin miss(2); fill(); end
        for (int i = 0; i < 4; i++) begin
            miss(2);
            chk_victim("t3_evict", i, 1);
            fill();
        end
        miss(2);
        chk_victim("t3_wrap", 0, 1);
        fill();

        // Scenario 4: a free way wins over the pointer, and the pointer stays put.
        for (int i = 0; i < 6; i++) begin miss(1); fill(); end
        inv(1, 3);
        miss(1);
        chk_victim("t4_invalid_first", 3, 0);
        fill();
        miss(1);
        chk_victim("t4_ptr_kept", 2, 1);
        fill();

        // Scenario 5: a hit does nothing, and requests are ignored while allocating.
        miss(4);
        fill();
        hit(4);
        chk("t5_hit_no_victim", int'(victim_valid), 0);
        miss(4);
        chk_victim("t5_miss", 1, 0);
        miss(6);
        chk("t5_ignored_ready", int'(req_ready), 0);
        chk_victim("t5_held", 1, 0);
        fill();
        miss(6);
        chk_victim("t5_set6_untouched", 0, 0);
        fill();

        // Scenario 6: a fill beats an invalidate of the same line; a reset mid-allocation abandons it.
        for (int i = 0; i < 2; i++) begin miss(7); fill(); end
        miss(7);
        chk_victim("t6_miss", 2, 0);
        fill_done = 1'b1;
        inv_valid = 1'b1;
        inv_index = 3'd7;
        inv_way = 2'd2;
        cyc();
        fill_done = 1'b0;
        inv_valid = 1'b0;
        miss(7);
        chk_victim("t6_fill_won", 3, 0);
        fill();
        miss(7);
        chk_victim("t6_full", 0, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_reset_vv", int'(victim_valid), 0);
        chk("t6_reset_ready", int'(req_ready), 1);
        miss(7);
        chk_victim("t6_after_reset", 0, 0);
        fill();

        // Random traffic concentrated on a few sets, so pointer wraps and invalidates actually occur.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 1) == 1);
            req_index = IDX_W'($urandom_range(0, 3));
            req_hit   = ($urandom_range(0, 9) < 3);
            fill_done = m_alloc ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
            inv_valid = ($urandom_range(0, 9) == 0);
            inv_index = IDX_W'($urandom_range(0, 3));
            inv_way   = WAY_W'($urandom_range(0, WAYS - 1));
            cyc();
        end
        reset = 1'b0;
        req_valid = 1'b0;
        inv_valid = 1'b0;
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        cyc();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
